// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the register bank write port
//
// Two requesters (ALU writeback A, memory load M) share one write port of a
// NREGS x DW register bank. One winner is chosen per non-stalled edge; its data
// and address are registered and presented on the next cycle as the I bus plus
// a one-hot Write strobe.
//
// Ports:
//   CLK            system clock, all state on rising edge
//   Reset          synchronous active-high reset
//   Stall          suppresses any new grant this cycle
//   A_req/addr/data ALU write request, held until A_gnt
//   M_req/addr/data memory write request, held until M_gnt
//   A_gnt, M_gnt   one-cycle pulse: that side's write is on the bus this cycle
//   I              data bus to every bank register
//   Write          one-hot load strobe, bit k loads register k at next edge
//   last_m         1 when the most recent grant went to M (round-robin pointer)
//
// NREGS must equal 2**AW; every AW-bit address names a real register.

module reg_write_arbiter #(
  parameter int DW    = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             A_req,
  input  logic [AW-1:0]    A_addr,
  input  logic [DW-1:0]    A_data,
  input  logic             M_req,
  input  logic [AW-1:0]    M_addr,
  input  logic [DW-1:0]    M_data,
  output logic             A_gnt,
  output logic             M_gnt,
  output logic [DW-1:0]    I,
  output logic [NREGS-1:0] Write,
  output logic             last_m
);

  logic             a_elig;
  logic             m_elig;
  logic             grant_a;
  logic             grant_m;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic [NREGS-1:0] win_onehot;

  // A requester whose grant is on the bus this cycle is still showing the
  // request it was just granted for, so it sits out one decision. This is what
  // prevents double grants and yields the forced gap between back-to-back
  // writes from one side.
  always_comb begin
    a_elig  = A_req & ~A_gnt;
    m_elig  = M_req & ~M_gnt;
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!Stall) begin
      // On a tie the side that did not win last time goes first.
      if (a_elig && (!m_elig || last_m)) begin
        grant_a = 1'b1;
      end else if (m_elig) begin
        grant_m = 1'b1;
      end
    end
  end

  always_comb begin
    win_addr = grant_m ? M_addr : A_addr;
    win_data = grant_m ? M_data : A_data;
    win_onehot = '0;
    win_onehot[win_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      A_gnt  <= 1'b0;
      M_gnt  <= 1'b0;
      Write  <= '0;
      I      <= '0;
      last_m <= 1'b1;
    end else begin
      A_gnt <= grant_a;
      M_gnt <= grant_m;
      if (grant_a || grant_m) begin
        Write  <= win_onehot;
        I      <= win_data;
        last_m <= grant_m;
      end else begin
        // I keeps its last value: the bank ignores it while Write is zero.
        Write <= '0;
      end
    end
  end

endmodule
